// File: rtl/membus_pkg.sv
// Shared Membus definitions: bus widths and responder FSM states.
// Imported by the Membus interface and the RAM responder.
package membus_pkg;

    localparam int MEMBUS_DATA_WIDTH = 32;
    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } membus_resp_state_t;

endpackage

// File: rtl/membus.sv
// Membus request/response bundle with master and slave views.
// Signals: valid/ready request handshake, addr, wen, wdata, wmask,
// and the one-cycle rvalid/rdata response.
interface membus
    import membus_pkg::*;
#(
    parameter int DATA_WIDTH = MEMBUS_DATA_WIDTH,
    parameter int ADDR_WIDTH = XLEN
);

    logic                    valid;
    logic                    ready;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    wen;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wmask;
    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   rdata;

    modport master (
        output valid, addr, wen, wdata, wmask,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  valid, addr, wen, wdata, wmask,
        output ready, rvalid, rdata
    );

endinterface

// File: rtl/membus_ram_bytemask_array.sv
// Word RAM with byte enables; one port, synchronous read-before-write.
// Ports: clk, en (access), we (write), idx (word), wdata, wmask, q (old word).
module membus_ram_bytemask_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4096
) (
    input  logic                      clk,
    input  logic                      en,
    input  logic                      we,
    input  logic [$clog2(DEPTH)-1:0]  idx,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wmask,
    output logic [DATA_WIDTH-1:0]     q
);

    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // q keeps the pre-write word, so a write also returns the old contents.
    // q only moves on an access and holds between accesses.
    always_ff @(posedge clk) begin
        if (en) begin
            q <= mem[idx];
            if (we) begin
                for (int b = 0; b < NB; b++) begin
                    if (wmask[b]) begin
                        mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/membus_ram_responder.sv
// Membus slave terminating each request in a byte-maskable RAM.
// Ports: clk, rst (async active-low), bus (Membus slave view).
module membus_ram_responder
    import membus_pkg::*;
#(
    parameter int DATA_WIDTH = MEMBUS_DATA_WIDTH,
    parameter int ADDR_WIDTH = XLEN,
    parameter int DEPTH      = 4096,
    parameter int LATENCY    = 2
) (
    input logic  clk,
    input logic  rst,
    membus.slave bus
);

    localparam int ADDR_LSB = $clog2(DATA_WIDTH / 8);
    localparam int IW       = $clog2(DEPTH);
    localparam int CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    if (ADDR_LSB + IW > ADDR_WIDTH) begin : g_addr_too_narrow
        $error("address too narrow for DEPTH");
    end
    if (LATENCY < 1) begin : g_bad_latency
        $error("LATENCY must be at least 1");
    end

    membus_resp_state_t    state;
    logic [CW-1:0]         cnt;
    logic                  rvalid_q;
    logic                  accept;
    logic [IW-1:0]         idx;
    logic [DATA_WIDTH-1:0] rbuf;

    // Ready depends on state only, so valid never loops back into ready.
    assign bus.ready = (state == IDLE) && rst;
    assign accept    = bus.valid && bus.ready;
    assign idx       = bus.addr[ADDR_LSB +: IW];

    // The array's output register is rbuf: it captures the old word on
    // the accept edge and holds it until the next accept.
    membus_ram_bytemask_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clk   (clk),
        .en    (accept),
        .we    (bus.wen),
        .idx   (idx),
        .wdata (bus.wdata),
        .wmask (bus.wmask),
        .q     (rbuf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        cnt <= CW'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            state    <= RESP;
                            rvalid_q <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state    <= RESP;
                        rvalid_q <= 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // rbuf is already valid when RESP is entered (even at LATENCY=1),
    // so the data path is only gated, not re-registered.
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rvalid_q ? rbuf : '0;

endmodule

// File: tb/tb_membus_ram_responder.sv
// Bench for membus_ram_responder at LATENCY=2 (dut0) and LATENCY=1 (dut1).
// Directed steps plus random traffic against a scoreboarded memory model.
module tb_membus_ram_responder;
    import membus_pkg::*;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic [3:0]  kn;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic        rstv  [2];
    logic        valid [2];
    logic        wen   [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  wmask [2];
    logic        rdy   [2];
    logic        rv    [2];
    logic [31:0] rd    [2];

    // Reference memory per DUT, with per-byte "known" flags.
    logic [31:0] mm [2][4096];
    logic [3:0]  mk [2][4096];
    exp_t        sb [2][$];
    int          rv_cnt  [2];
    logic [31:0] last_rd [2];

    membus b0 ();
    membus b1 ();

    assign b0.valid = valid[0];
    assign b0.addr  = addr[0];
    assign b0.wen   = wen[0];
    assign b0.wdata = wdata[0];
    assign b0.wmask = wmask[0];
    assign rdy[0]   = b0.ready;
    assign rv[0]    = b0.rvalid;
    assign rd[0]    = b0.rdata;

    assign b1.valid = valid[1];
    assign b1.addr  = addr[1];
    assign b1.wen   = wen[1];
    assign b1.wdata = wdata[1];
    assign b1.wmask = wmask[1];
    assign rdy[1]   = b1.ready;
    assign rv[1]    = b1.rvalid;
    assign rd[1]    = b1.rdata;

    membus_ram_responder #(
        .DEPTH   (4096),
        .LATENCY (2)
    ) u_dut0 (
        .clk (clk),
        .rst (rstv[0]),
        .bus (b0.slave)
    );

    membus_ram_responder #(
        .DEPTH   (4096),
        .LATENCY (1)
    ) u_dut1 (
        .clk (clk),
        .rst (rstv[1]),
        .bus (b1.slave)
    );

    function automatic int lat(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic logic [31:0] bytes_of(input logic [3:0] m);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = {8{m[b]}};
        end
        return r;
    endfunction

    task automatic chk(input int d, input string tag,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL dut%0d %s: observed %h expected %h", d, tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard: every accepted request owes exactly one rvalid,
    // LATENCY cycles after its accept edge; the DUT is ready iff nothing
    // is outstanding.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rstv[d]) begin
                sb[d].delete();
                chk(d, "rst_ready",  32'(rdy[d]), 32'd0);
                chk(d, "rst_rvalid", 32'(rv[d]),  32'd0);
                chk(d, "rst_rdata",  rd[d],       32'd0);
            end else begin
                logic exp_rv;
                exp_rv = (sb[d].size() != 0) && (sb[d][0].due == cyc);
                chk(d, "ready",  32'(rdy[d]), 32'(sb[d].size() == 0));
                chk(d, "rvalid", 32'(rv[d]),  32'(exp_rv));
                if (exp_rv) begin
                    exp_t e;
                    e = sb[d].pop_front();
                    if (rv[d]) begin
                        chk(d, "rdata", rd[d] & bytes_of(e.kn),
                            e.data & bytes_of(e.kn));
                        rv_cnt[d]++;
                        last_rd[d] = rd[d];
                    end
                end else begin
                    chk(d, "rdata_idle", rd[d], 32'd0);
                end
                if (valid[d] && rdy[d]) begin
                    exp_t e;
                    int   w;
                    w      = int'((addr[d] >> 2) % 4096);
                    e.due  = cyc + lat(d);
                    e.data = mm[d][w];
                    e.kn   = mk[d][w];
                    sb[d].push_back(e);
                    if (wen[d]) begin
                        for (int b = 0; b < 4; b++) begin
                            if (wmask[d][b]) begin
                                mm[d][w][8*b +: 8] = wdata[d][8*b +: 8];
                                mk[d][w][b]        = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    // Called just after a posedge; returns just after the accept edge.
    task automatic req(input int d, input logic [31:0] a, input logic w,
                       input logic [31:0] wd, input logic [3:0] wm);
        int ok;
        int n;
        addr[d]  = a;
        wen[d]   = w;
        wdata[d] = wd;
        wmask[d] = wm;
        valid[d] = 1'b1;
        ok = 0;
        n  = 0;
        while (ok == 0 && n < 20) begin
            @(negedge clk);
            if (rdy[d]) ok = 1;
            n++;
        end
        chk(d, "accept_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        valid[d] = 1'b0;
    endtask

    task automatic settle(input int d);
        int n;
        n = 0;
        while (sb[d].size() != 0 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(d, "drain_timeout", 32'(sb[d].size()), 32'd0);
    endtask

    task automatic run_directed(input int d);
        int n0;
        int acc;

        n0 = rv_cnt[d];
        req(d, 32'h1000, 1'b1, 32'hDEADBEEF, 4'hF);
        settle(d);
        req(d, 32'h1000, 1'b0, 32'h0, 4'h0);
        settle(d);
        chk(d, "t2_read", last_rd[d], 32'hDEADBEEF);
        chk(d, "t2_rvalid_count", 32'(rv_cnt[d] - n0), 32'd2);

        req(d, 32'h1000, 1'b1, 32'h000000AA, 4'h1);
        settle(d);
        chk(d, "t3_write_old", last_rd[d], 32'hDEADBEEF);
        req(d, 32'h1000, 1'b0, 32'h0, 4'h0);
        settle(d);
        chk(d, "t3_read", last_rd[d], 32'hDEADBEAA);

        n0       = rv_cnt[d];
        addr[d]  = 32'h1000;
        wen[d]   = 1'b0;
        valid[d] = 1'b1;
        acc      = 0;
        repeat (10) begin
            @(negedge clk);
            if (rdy[d]) acc++;
        end
        @(posedge clk);
        #1;
        valid[d] = 1'b0;
        settle(d);
        chk(d, "t4_accepts", 32'(acc), 32'((10 + lat(d)) / (lat(d) + 1)));
        chk(d, "t4_rvalids", 32'(rv_cnt[d] - n0), 32'(acc));
        chk(d, "t4_data", last_rd[d], 32'hDEADBEAA);

        req(d, 32'h0, 1'b1, 32'h00000055, 4'hF);
        settle(d);
        req(d, 32'h4000, 1'b0, 32'h0, 4'h0);
        settle(d);
        chk(d, "t5_alias", last_rd[d], 32'h00000055);

        n0 = rv_cnt[d];
        req(d, 32'h20, 1'b1, 32'h12345678, 4'hF);
        rstv[d] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk(d, "t6_rst_ready",  32'(rdy[d]), 32'd0);
        chk(d, "t6_rst_rvalid", 32'(rv[d]),  32'd0);
        rstv[d] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk(d, "t6_dropped", 32'(rv_cnt[d] - n0), 32'd0);
        req(d, 32'h20, 1'b0, 32'h0, 4'h0);
        settle(d);
        chk(d, "t6_committed", last_rd[d], 32'h12345678);
    endtask

    task automatic run_random(input int d);
        int          pool [8];
        int          n0;
        logic [31:0] a;
        pool[0] = 0;
        pool[1] = 4095;
        pool[2] = 8;
        pool[3] = 1024;
        for (int k = 4; k < 8; k++) pool[k] = int'($urandom_range(4095));
        n0 = rv_cnt[d];
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(2)) begin
                @(posedge clk);
                #1;
            end
            a = ($urandom & 32'hFFFF_C000)
              | (32'(pool[$urandom_range(7)]) << 2)
              | ($urandom & 32'h3);
            req(d, a, 1'($urandom_range(1)), $urandom, 4'($urandom));
        end
        settle(d);
        chk(d, "rand_rvalid_count", 32'(rv_cnt[d] - n0), 32'd40);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rstv[d]    = 1'b1;
            valid[d]   = 1'b0;
            wen[d]     = 1'b0;
            addr[d]    = '0;
            wdata[d]   = '0;
            wmask[d]   = '0;
            rv_cnt[d]  = 0;
            last_rd[d] = '0;
            for (int w = 0; w < 4096; w++) mk[d][w] = 4'h0;
        end
        #1;
        rstv[0] = 1'b0;
        rstv[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk(d, "t1_ready",  32'(rdy[d]), 32'd0);
            chk(d, "t1_rvalid", 32'(rv[d]),  32'd0);
            chk(d, "t1_rdata",  rd[d],       32'd0);
        end
        rstv[0] = 1'b1;
        rstv[1] = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk(d, "t1_ready_after", 32'(rdy[d]), 32'd1);
        end
        @(posedge clk);
        #1;

        for (int d = 0; d < 2; d++) begin
            run_directed(d);
            run_random(d);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
